// File: rtl/fetch_decode.sv
// fetch_decode: front end of the 16-bit LC-3-style core.
// Fetches one instruction word from imem at IP, decodes it into the field
// bundle consumed by execute, then waits for the resolved next_IP.
// Exactly one instruction is in flight and there is no prefetch.
// Optional feature macro: ILLEGAL_OP_EN. When it is defined, opcode 4'b1101
// sets a sticky illegal_op flag and parks the core until reset. When it is
// not defined, that opcode is issued as an all-zero NOP bundle.
// The instruction class output is named inst_type because "type" is a
// SystemVerilog keyword.

module fetch_decode #(
  parameter logic [15:0] RESET_IP = 16'h3000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        dec_valid,
  input  logic        exe_ready,
  output logic [15:0] inst,
  output logic [4:0]  inst_type,
  output logic [2:0]  SR1,
  output logic [2:0]  SR2,
  output logic [2:0]  DR,
  output logic [15:0] imm,
  output logic [15:0] IP,
  input  logic [15:0] next_IP,
  input  logic        next_IP_valid
`ifdef ILLEGAL_OP_EN
  ,output logic       illegal_op
`endif
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT_MEM,
    S_DECODE,
    S_ISSUE,
    S_WAIT_NEXT,
    S_HALT
  } state_e;

  typedef enum logic [3:0] {
    OP_BR   = 4'h0,
    OP_ADD  = 4'h1,
    OP_LD   = 4'h2,
    OP_ST   = 4'h3,
    OP_JSR  = 4'h4,
    OP_AND  = 4'h5,
    OP_LDR  = 4'h6,
    OP_STR  = 4'h7,
    OP_RTI  = 4'h8,
    OP_NOT  = 4'h9,
    OP_LDI  = 4'hA,
    OP_STI  = 4'hB,
    OP_JMP  = 4'hC,
    OP_RES  = 4'hD,
    OP_LEA  = 4'hE,
    OP_TRAP = 4'hF
  } opcode_e;

  state_e      state;
  state_e      state_n;
  logic [15:0] fetch_word;
  opcode_e     op;

  logic        capture;
  logic        load_dec;
  logic        load_ip;

  logic [15:0] d_inst;
  logic [4:0]  d_type;
  logic        d_mode;
  logic [2:0]  d_sr1;
  logic [2:0]  d_sr2;
  logic [2:0]  d_dr;
  logic [15:0] d_imm;
`ifdef ILLEGAL_OP_EN
  logic        d_illegal;
`endif

  assign op        = opcode_e'(fetch_word[15:12]);
  assign imem_addr = IP;

  // Field extraction from the captured instruction word.
  always_comb begin
    d_inst = fetch_word;
    d_mode = 1'b0;
    d_sr1  = '0;
    d_sr2  = '0;
    d_dr   = fetch_word[11:9];
    d_imm  = '0;
    d_type = '0;
`ifdef ILLEGAL_OP_EN
    d_illegal = 1'b0;
`endif
    case (op)
      OP_ADD, OP_AND: begin
        d_mode = fetch_word[5];
        d_sr1  = fetch_word[8:6];
        if (!fetch_word[5]) d_sr2 = fetch_word[2:0];
        d_imm  = {{11{fetch_word[4]}}, fetch_word[4:0]};
      end
      OP_BR, OP_LD, OP_LDI, OP_LEA: begin
        d_imm = {{7{fetch_word[8]}}, fetch_word[8:0]};
      end
      OP_ST, OP_STI: begin
        d_sr2 = fetch_word[11:9];
        d_imm = {{7{fetch_word[8]}}, fetch_word[8:0]};
      end
      OP_JSR: begin
        d_mode = fetch_word[11];
        if (fetch_word[11]) d_imm = {{5{fetch_word[10]}}, fetch_word[10:0]};
        else                d_sr1 = fetch_word[8:6];
      end
      OP_LDR: begin
        d_sr1 = fetch_word[8:6];
        d_imm = {{10{fetch_word[5]}}, fetch_word[5:0]};
      end
      OP_STR: begin
        d_sr1 = fetch_word[8:6];
        d_sr2 = fetch_word[11:9];
        d_imm = {{10{fetch_word[5]}}, fetch_word[5:0]};
      end
      OP_NOT, OP_JMP: begin
        d_sr1 = fetch_word[8:6];
      end
      OP_TRAP: begin
        d_imm = {8'h00, fetch_word[7:0]};
      end
      OP_RES: begin
`ifdef ILLEGAL_OP_EN
        d_illegal = 1'b1;
`else
        d_inst = '0;
        d_dr   = '0;
`endif
      end
      OP_RTI: ;
      default: ;
    endcase
    // Built from d_inst so the NOP substitution also clears the opcode bits.
    d_type = {d_mode, d_inst[15:12]};
`ifdef ILLEGAL_OP_EN
    if (d_illegal) d_type = '1;
`endif
  end

  // Next-state and handshake outputs of the fetch/issue sequencer.
  always_comb begin
    state_n   = state;
    imem_req  = 1'b0;
    dec_valid = 1'b0;
    capture   = 1'b0;
    load_dec  = 1'b0;
    load_ip   = 1'b0;
    case (state)
      S_FETCH: begin
        state_n = S_WAIT_MEM;
      end
      S_WAIT_MEM: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          capture = 1'b1;
          state_n = S_DECODE;
        end
      end
      S_DECODE: begin
        load_dec = 1'b1;
        state_n  = S_ISSUE;
`ifdef ILLEGAL_OP_EN
        if (d_illegal) state_n = S_HALT;
`endif
      end
      S_ISSUE: begin
        dec_valid = 1'b1;
        if (exe_ready) begin
          // A next_IP arriving with the accept skips the WAIT_NEXT bubble.
          if (next_IP_valid) begin
            load_ip = 1'b1;
            state_n = S_WAIT_MEM;
          end else begin
            state_n = S_WAIT_NEXT;
          end
        end
      end
      S_WAIT_NEXT: begin
        if (next_IP_valid) begin
          load_ip = 1'b1;
          state_n = S_WAIT_MEM;
        end
      end
      S_HALT: ;
      default: state_n = S_FETCH;
    endcase
  end

  // State, IP, fetched word and the registered decode bundle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_FETCH;
      IP         <= RESET_IP;
      fetch_word <= '0;
      inst       <= '0;
      inst_type  <= '0;
      SR1        <= '0;
      SR2        <= '0;
      DR         <= '0;
      imm        <= '0;
`ifdef ILLEGAL_OP_EN
      illegal_op <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (capture) fetch_word <= imem_rdata;
      if (load_ip) IP <= next_IP;
      if (load_dec) begin
        inst      <= d_inst;
        inst_type <= d_type;
        SR1       <= d_sr1;
        SR2       <= d_sr2;
        DR        <= d_dr;
        imm       <= d_imm;
      end
`ifdef ILLEGAL_OP_EN
      if (load_dec && d_illegal) illegal_op <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_decode.sv
// tb_fetch_decode: table-driven, hand-sequenced and randomized checks of
// fetch_decode against an arithmetic decode model.

module tb_fetch_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        dec_valid;
  logic        exe_ready;
  logic [15:0] inst;
  logic [4:0]  inst_type;
  logic [2:0]  SR1, SR2, DR;
  logic [15:0] imm;
  logic [15:0] IP;
  logic [15:0] next_IP;
  logic        next_IP_valid;
`ifdef ILLEGAL_OP_EN
  logic        illegal_op;
`endif

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_ip;

  always #5 clk = ~clk;

  fetch_decode #(.RESET_IP(16'h3000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dec_valid(dec_valid), .exe_ready(exe_ready),
    .inst(inst), .inst_type(inst_type),
    .SR1(SR1), .SR2(SR2), .DR(DR), .imm(imm), .IP(IP),
    .next_IP(next_IP), .next_IP_valid(next_IP_valid)
`ifdef ILLEGAL_OP_EN
    ,.illegal_op(illegal_op)
`endif
  );

  typedef struct packed {
    logic [15:0] inst;
    logic [4:0]  typ;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic [2:0]  dr;
    logic [15:0] imm;
  } bundle_t;

  typedef struct {
    logic [15:0] word;
    logic [4:0]  typ;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic [2:0]  dr;
    logic [15:0] imm;
    int unsigned ack_dly;
    int unsigned rdy_dly;
    bit          same;
    logic [15:0] nip;
    int unsigned nip_dly;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decode rules written as opcode sets and plain integer sign extension.
  function automatic bundle_t ref_decode(input logic [15:0] w);
    bundle_t     b;
    int unsigned op;
    int          n;
    int          v;
    logic        mode;
    bit          alu;
    op   = int'(w[15:12]);
    alu  = (op == 1) || (op == 5);
    b    = '0;
    b.inst = w;
    b.dr   = w[11:9];
    mode = alu ? w[5] : ((op == 4) ? w[11] : 1'b0);
    b.typ = {mode, w[15:12]};
    if (alu || op == 9 || op == 6 || op == 7 || op == 12 || (op == 4 && !w[11]))
      b.sr1 = w[8:6];
    if (alu && !w[5]) b.sr2 = w[2:0];
    else if (op == 3 || op == 11 || op == 7) b.sr2 = w[11:9];
    n = 0;
    if (alu) n = 5;
    else if (op == 0 || op == 2 || op == 3 || op == 10 || op == 11 || op == 14) n = 9;
    else if (op == 4 && w[11]) n = 11;
    else if (op == 6 || op == 7) n = 6;
    if (n > 0) begin
      v = int'(w) % (1 << n);
      if (v >= (1 << (n - 1))) v = v - (1 << n);
      b.imm = 16'(v);
    end
    if (op == 15) b.imm = 16'(int'(w) % 256);
    if (op == 13) b = '0;
    return b;
  endfunction

  task automatic check_bundle(input string tag, input bundle_t e);
    check({tag, "_inst"}, inst, e.inst);
    check({tag, "_type"}, inst_type, e.typ);
    check({tag, "_sr1"}, SR1, e.sr1);
    check({tag, "_sr2"}, SR2, e.sr2);
    check({tag, "_dr"}, DR, e.dr);
    check({tag, "_imm"}, imm, e.imm);
    check({tag, "_ip"}, IP, exp_ip);
  endtask

  // Runs one instruction from WAIT_MEM through accept and next-IP return.
  task automatic run_instr(input bundle_t e, input logic [15:0] word,
                           input int unsigned ack_dly, input int unsigned rdy_dly,
                           input bit same, input logic [15:0] nip,
                           input int unsigned nip_dly);
    check("req_wait", imem_req, 1);
    check("addr_wait", imem_addr, exp_ip);
    for (int unsigned i = 0; i < ack_dly; i++) begin
      next_IP_valid = 1'($urandom_range(0, 1));
      next_IP       = 16'($urandom);
      imem_rdata    = 16'($urandom);
      tick();
      check("req_held", imem_req, 1);
      check("addr_held", imem_addr, exp_ip);
      check("dv_wait", dec_valid, 0);
    end
    next_IP_valid = 1'b0;
    imem_ack      = 1'b1;
    imem_rdata    = word;
    tick();
    imem_ack      = 1'b0;
    imem_rdata    = 16'($urandom);
    next_IP_valid = 1'($urandom_range(0, 1));
    next_IP       = 16'($urandom);
    check("req_drop", imem_req, 0);
    check("dv_decode", dec_valid, 0);
    tick();
    next_IP_valid = 1'b0;
    check("dv_issue", dec_valid, 1);
    check_bundle("issue", e);
    for (int unsigned i = 0; i < rdy_dly; i++) begin
      next_IP_valid = 1'($urandom_range(0, 1));
      next_IP       = 16'($urandom);
      tick();
      check("dv_hold", dec_valid, 1);
      check("req_hold", imem_req, 0);
      check_bundle("hold", e);
    end
    exe_ready     = 1'b1;
    next_IP_valid = same;
    next_IP       = nip;
    tick();
    exe_ready     = 1'b0;
    next_IP_valid = 1'b0;
    check("dv_accept", dec_valid, 0);
    if (same) begin
      check("req_direct", imem_req, 1);
      check("addr_direct", imem_addr, nip);
    end else begin
      check("req_wnext", imem_req, 0);
      for (int unsigned i = 0; i < nip_dly; i++) begin
        tick();
        check("req_wnext_idle", imem_req, 0);
      end
      next_IP_valid = 1'b1;
      next_IP       = nip;
      tick();
      next_IP_valid = 1'b0;
      check("req_next", imem_req, 1);
      check("addr_next", imem_addr, nip);
    end
    exp_ip = nip;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bundle_t     e;
    logic [15:0] w;

    vecs[0]  = '{16'h1261, 5'h11, 3'd1, 3'd0, 3'd1, 16'h0001, 0, 0, 1'b1, 16'h3010, 0};
    vecs[1]  = '{16'h64FE, 5'h06, 3'd3, 3'd0, 3'd2, 16'hFFFE, 0, 3, 1'b0, 16'h3011, 1};
    vecs[2]  = '{16'h5705, 5'h05, 3'd4, 3'd5, 3'd3, 16'h0005, 4, 0, 1'b1, 16'h3012, 0};
    vecs[3]  = '{16'h7B83, 5'h07, 3'd6, 3'd5, 3'd5, 16'h0003, 1, 1, 1'b0, 16'hFFFF, 2};
    vecs[4]  = '{16'h41C0, 5'h04, 3'd7, 3'd0, 3'd0, 16'h0000, 0, 0, 1'b1, 16'h0000, 0};
    vecs[5]  = '{16'h4C00, 5'h14, 3'd0, 3'd0, 3'd6, 16'hFC00, 2, 2, 1'b1, 16'h3020, 0};
    vecs[6]  = '{16'h0FFF, 5'h00, 3'd0, 3'd0, 3'd7, 16'hFFFF, 0, 0, 1'b0, 16'h3021, 0};
    vecs[7]  = '{16'h34FF, 5'h03, 3'd0, 3'd2, 3'd2, 16'h00FF, 1, 0, 1'b1, 16'h3022, 0};
    vecs[8]  = '{16'hF025, 5'h0F, 3'd0, 3'd0, 3'd0, 16'h0025, 0, 1, 1'b0, 16'h3023, 3};
    vecs[9]  = '{16'h92BF, 5'h09, 3'd2, 3'd0, 3'd1, 16'h0000, 0, 0, 1'b1, 16'h3024, 0};
    vecs[10] = '{16'hE900, 5'h0E, 3'd0, 3'd0, 3'd4, 16'hFF00, 0, 0, 1'b1, 16'h3025, 0};
    vecs[11] = '{16'hC1C0, 5'h0C, 3'd7, 3'd0, 3'd0, 16'h0000, 0, 0, 1'b0, 16'h3026, 1};
    vecs[12] = '{16'h8000, 5'h08, 3'd0, 3'd0, 3'd0, 16'h0000, 0, 0, 1'b1, 16'h3027, 0};
    vecs[13] = '{16'hB601, 5'h0B, 3'd0, 3'd3, 3'd3, 16'h0001, 0, 0, 1'b1, 16'h3028, 0};
    vecs[14] = '{16'h1070, 5'h11, 3'd1, 3'd0, 3'd0, 16'hFFF0, 3, 2, 1'b1, 16'h3029, 0};
    vecs[15] = '{16'hA202, 5'h0A, 3'd0, 3'd0, 3'd1, 16'h0002, 0, 0, 1'b0, 16'h3030, 0};

    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    exe_ready = 1'b0; next_IP = '0; next_IP_valid = 1'b0;
    repeat (3) tick();

    // Reset state.
    check("rst_req", imem_req, 0);
    check("rst_dv", dec_valid, 0);
    check("rst_ip", IP, 16'h3000);
    check("rst_inst", inst, 0);
    check("rst_type", inst_type, 0);
    check("rst_sr1", SR1, 0);
    check("rst_sr2", SR2, 0);
    check("rst_dr", DR, 0);
    check("rst_imm", imm, 0);
`ifdef ILLEGAL_OP_EN
    check("rst_illegal", illegal_op, 0);
`endif

    // One idle cycle, then the first request at RESET_IP.
    rst_n = 1'b1;
    check("idle_req", imem_req, 0);
    tick();
    check("first_req", imem_req, 1);
    check("first_addr", imem_addr, 16'h3000);

    // Reset during WAIT_MEM abandons the fetch; a late ack is ignored.
    tick();
    check("pre_rst_req", imem_req, 1);
    rst_n = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 16'h1261;
    tick();
    check("wm_rst_req", imem_req, 0);
    check("wm_rst_ip", IP, 16'h3000);
    rst_n = 1'b1;
    tick();
    imem_ack = 1'b0;
    check("late_ack_req", imem_req, 1);
    tick();
    check("late_ack_dv", dec_valid, 0);
    check("late_ack_req2", imem_req, 1);
    exp_ip = 16'h3000;

    // Directed table.
    for (int i = 0; i < 16; i++) begin
      e.inst = vecs[i].word;
      e.typ  = vecs[i].typ;
      e.sr1  = vecs[i].sr1;
      e.sr2  = vecs[i].sr2;
      e.dr   = vecs[i].dr;
      e.imm  = vecs[i].imm;
      run_instr(e, vecs[i].word, vecs[i].ack_dly, vecs[i].rdy_dly,
                vecs[i].same, vecs[i].nip, vecs[i].nip_dly);
    end

    // Randomized instructions against the reference model.
    for (int i = 0; i < 200; i++) begin
      w = 16'($urandom);
`ifdef ILLEGAL_OP_EN
      if (w[15:12] == 4'hD) w[15:12] = 4'h1;
`endif
      e = ref_decode(w);
      run_instr(e, w, $urandom_range(0, 4), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 16'($urandom), $urandom_range(0, 3));
    end

    // Reserved opcode 1101.
`ifdef ILLEGAL_OP_EN
    imem_ack = 1'b1;
    imem_rdata = 16'hD000;
    tick();
    imem_ack = 1'b0;
    tick();
    check("ill_dv", dec_valid, 0);
    check("ill_flag", illegal_op, 1);
    check("ill_type", inst_type, 5'h1F);
    for (int i = 0; i < 4; i++) begin
      exe_ready = 1'b1;
      next_IP_valid = 1'b1;
      next_IP = 16'h4000;
      tick();
      check("halt_dv", dec_valid, 0);
      check("halt_req", imem_req, 0);
      check("halt_flag", illegal_op, 1);
    end
    exe_ready = 1'b0;
    next_IP_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    check("ill_clear", illegal_op, 0);
    rst_n = 1'b1;
    tick();
    check("ill_refetch_req", imem_req, 1);
    check("ill_refetch_addr", imem_addr, 16'h3000);
`else
    e = '0;
    run_instr(e, 16'hD000, 1, 1, 1'b1, 16'h3100, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
